// File: rtl/motion_sequencer.sv
// rtl/motion_sequencer.sv - line-follower motion supervisor with debounce, dwell, dead-time coast and duty soft-start
//
// Purpose: debounces the three line sensors, picks a motion, holds it for a
// minimum dwell, inserts a coast between two motions and ramps the PWM duty.
// Ports:
//   i_clk        system clock
//   i_reset      synchronous active-high reset
//   i_sensors    raw {f, l, r} line sensors
//   i_enable     run permission, low forces STANDBY
//   i_duty_max   ceiling for the ramped duty
//   o_motor_a    {fwd, rev} for motor A
//   o_motor_b    {fwd, rev} for motor B
//   o_duty       duty command to the PWM generator
//   o_state      STANDBY=0 FORWARD=1 RIGHT=2 LEFT=3 COAST=4
//   o_busy       high while in COAST
module motion_sequencer #(
  parameter int DEB_CYCLES = 4,
  parameter int DWELL      = 16,
  parameter int DEAD       = 8,
  parameter int RAMP_STEP  = 32,
  parameter int TICK_DIV   = 10
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [2:0] i_sensors,
  input  logic       i_enable,
  input  logic [7:0] i_duty_max,
  output logic [1:0] o_motor_a,
  output logic [1:0] o_motor_b,
  output logic [7:0] o_duty,
  output logic [2:0] o_state,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    ST_STANDBY = 3'd0,
    ST_FORWARD = 3'd1,
    ST_RIGHT   = 3'd2,
    ST_LEFT    = 3'd3,
    ST_COAST   = 3'd4
  } state_t;

  localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
  localparam int DWELL_W = $clog2(DWELL + 1);
  localparam int DEAD_W  = $clog2(DEAD + 1);
  localparam int TICK_W  = $clog2(TICK_DIV + 1);

  state_t                  r_state;
  state_t                  r_pending;
  logic [2:0]              r_deb;
  logic [2:0][DEB_W-1:0]   r_deb_cnt;
  logic [DWELL_W-1:0]      r_dwell;
  logic [DEAD_W-1:0]       r_dead_cnt;
  logic [TICK_W-1:0]       r_tick;
  logic [7:0]              r_duty;

  state_t                  w_desired;
  state_t                  w_next;
  logic                    w_latch;
  logic                    w_entry;
  logic                    w_motion;
  logic [8:0]              w_sum;

  // Debounce: a bit only follows raw after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_deb     <= 3'b111;
      r_deb_cnt <= '0;
    end else begin
      for (int b = 0; b < 3; b++) begin
        if (i_sensors[b] == r_deb[b]) begin
          r_deb_cnt[b] <= '0;
        end else if (r_deb_cnt[b] == DEB_W'(DEB_CYCLES - 1)) begin
          r_deb[b]     <= i_sensors[b];
          r_deb_cnt[b] <= '0;
        end else begin
          r_deb_cnt[b] <= r_deb_cnt[b] + 1'b1;
        end
      end
    end
  end

  // Desired motion from debounced {f, l, r}.
  always_comb begin
    w_desired = ST_STANDBY;
    case (r_deb)
      3'b000, 3'b011:         w_desired = ST_FORWARD;
      3'b010, 3'b110, 3'b100: w_desired = ST_RIGHT;
      3'b001, 3'b101:         w_desired = ST_LEFT;
      default:                w_desired = ST_STANDBY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_STANDBY;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_latch   = 1'b0;
    o_motor_a = 2'b00;
    o_motor_b = 2'b00;
    if (!i_enable) begin
      w_next = ST_STANDBY;
    end else begin
      case (r_state)
        ST_STANDBY: w_next = w_desired;
        // Sensors are ignored here; the target was frozen on COAST entry.
        ST_COAST: begin
          if (r_dead_cnt == DEAD_W'(DEAD - 1)) w_next = r_pending;
        end
        ST_FORWARD, ST_RIGHT, ST_LEFT: begin
          // A change seen before dwell expires stays pending in w_desired
          // and is taken here once dwell saturates, if still wanted.
          if (r_dwell == DWELL_W'(DWELL) && w_desired != r_state) begin
            if (w_desired == ST_STANDBY) begin
              w_next = ST_STANDBY;
            end else begin
              w_next  = ST_COAST;
              w_latch = 1'b1;
            end
          end
        end
        default: w_next = ST_STANDBY;
      endcase
    end
    case (r_state)
      ST_FORWARD: begin o_motor_a = 2'b10; o_motor_b = 2'b10; end
      ST_RIGHT:   begin o_motor_a = 2'b10; o_motor_b = 2'b01; end
      ST_LEFT:    begin o_motor_a = 2'b01; o_motor_b = 2'b10; end
      default:    begin o_motor_a = 2'b00; o_motor_b = 2'b00; end
    endcase
  end

  assign w_entry  = (w_next != r_state);
  assign w_motion = (r_state == ST_FORWARD) || (r_state == ST_RIGHT) || (r_state == ST_LEFT);
  // Nine-bit sum so the ramp clamps instead of wrapping past 255.
  assign w_sum    = {1'b0, r_duty} + 9'(RAMP_STEP);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pending  <= ST_STANDBY;
      r_dwell    <= '0;
      r_dead_cnt <= '0;
      r_tick     <= '0;
      r_duty     <= '0;
    end else begin
      if (w_latch) r_pending <= w_desired;
      if (w_entry) begin
        r_dwell    <= '0;
        r_dead_cnt <= '0;
        r_tick     <= '0;
        r_duty     <= '0;
      end else begin
        if (r_state == ST_COAST) r_dead_cnt <= r_dead_cnt + 1'b1;
        if (w_motion) begin
          if (r_dwell != DWELL_W'(DWELL)) r_dwell <= r_dwell + 1'b1;
          if (r_tick == TICK_W'(TICK_DIV - 1)) begin
            r_tick <= '0;
            r_duty <= (w_sum > {1'b0, i_duty_max}) ? i_duty_max : w_sum[7:0];
          end else begin
            r_tick <= r_tick + 1'b1;
            // A lowered ceiling takes effect immediately, not on the next tick.
            if (i_duty_max < r_duty) r_duty <= i_duty_max;
          end
        end
      end
    end
  end

  assign o_duty  = r_duty;
  assign o_state = r_state;
  assign o_busy  = (r_state == ST_COAST);

endmodule

// File: tb/tb_motion_sequencer.sv
// tb/tb_motion_sequencer.sv - self-checking bench for motion_sequencer
module tb_motion_sequencer;

  localparam int DEB   = 4;
  localparam int DWELL = 16;
  localparam int DEAD  = 8;
  localparam int STEP  = 32;
  localparam int TICK  = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] sensors;
  logic       enable;
  logic [7:0] duty_max;
  logic [1:0] motor_a;
  logic [1:0] motor_b;
  logic [7:0] duty;
  logic [2:0] state_o;
  logic       busy;

  motion_sequencer dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_sensors  (sensors),
    .i_enable   (enable),
    .i_duty_max (duty_max),
    .o_motor_a  (motor_a),
    .o_motor_b  (motor_b),
    .o_duty     (duty),
    .o_state    (state_o),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: ages, run lengths and a lookup table.
  int       m_state;
  int       m_age;
  int       m_target;
  int       m_duty;
  bit [2:0] m_deb;
  int       m_run [3];
  int       want_lut [8] = '{1, 3, 2, 1, 2, 3, 2, 0};
  logic [1:0] exp_a_lut [5] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b00};
  logic [1:0] exp_b_lut [5] = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b00};

  bit [2:0] cur_s;
  bit       cur_en;
  bit [7:0] cur_dm;

  function automatic bit is_motion(input int s);
    return (s >= 1) && (s <= 3);
  endfunction

  task automatic model_step(input bit r, input bit [2:0] s, input bit en, input bit [7:0] dm);
    int nxt;
    int w;
    if (r) begin
      m_state = 0; m_age = 0; m_target = 0; m_duty = 0; m_deb = 3'b111;
      for (int b = 0; b < 3; b++) m_run[b] = 0;
      return;
    end
    w   = want_lut[m_deb];
    nxt = m_state;
    if (!en) nxt = 0;
    else if (m_state == 0) nxt = w;
    else if (m_state == 4) begin
      if (m_age == DEAD - 1) nxt = m_target;
    end else if (m_age >= DWELL && w != m_state) begin
      if (w == 0) nxt = 0;
      else begin nxt = 4; m_target = w; end
    end
    for (int b = 0; b < 3; b++) begin
      if (s[b] != m_deb[b]) begin
        m_run[b]++;
        if (m_run[b] == DEB) begin m_deb[b] = s[b]; m_run[b] = 0; end
      end else m_run[b] = 0;
    end
    if (nxt != m_state) begin
      m_age = 0; m_duty = 0;
    end else begin
      m_age++;
      if (is_motion(nxt)) begin
        if (m_age % TICK == 0) m_duty = (m_duty + STEP > dm) ? dm : m_duty + STEP;
        else if (dm < m_duty) m_duty = dm;
      end else m_duty = 0;
    end
    m_state = nxt;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit [2:0] s, input bit en, input bit [7:0] dm);
    reset = r; sensors = s; enable = en; duty_max = dm;
    @(posedge clk);
    model_step(r, s, en, dm);
    #1;
    n_vec++;
    if ({state_o, motor_a, motor_b, duty, busy} !==
        {3'(m_state), exp_a_lut[m_state], exp_b_lut[m_state], 8'(m_duty), (m_state == 4)}) begin
      n_bad++;
      $display("FAIL model: state %0d a %b b %b duty %0d busy %b, expected state %0d a %b b %b duty %0d busy %0d at %0t",
               state_o, motor_a, motor_b, duty, busy, m_state, exp_a_lut[m_state], exp_b_lut[m_state],
               m_duty, (m_state == 4), $time);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, cur_s, cur_en, cur_dm);
  endtask

  task automatic do_reset();
    cyc(1'b1, cur_s, cur_en, cur_dm);
  endtask

  task automatic wait_state(input int st, input int limit, input string name);
    int k;
    k = 0;
    while (state_o !== 3'(st) && k < limit) begin step(1); k++; end
    check(name, 32'(state_o), 32'(st));
  endtask

  typedef struct {
    bit       rst;
    bit [2:0] sens;
    bit       en;
    bit [7:0] dmax;
    int       reps;
    int       e_state;
    int       e_duty;
    bit [1:0] e_a;
    bit [1:0] e_b;
    bit       e_busy;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(input bit rst, input bit [2:0] sens, input bit en, input bit [7:0] dmax,
                              input int reps, input int st, input int d, input bit [1:0] a,
                              input bit [1:0] b, input bit bz);
    vec_t v;
    v.rst = rst; v.sens = sens; v.en = en; v.dmax = dmax; v.reps = reps;
    v.e_state = st; v.e_duty = d; v.e_a = a; v.e_b = b; v.e_busy = bz;
    return v;
  endfunction

  initial begin
    int hold;
    int en_off;

    tbl.push_back(mk(1, 3'b000, 1, 200,  1, 0,   0, 2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 3'b000, 1, 200,  4, 0,   0, 2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 3'b000, 1, 200,  1, 1,   0, 2'b10, 2'b10, 0));
    tbl.push_back(mk(0, 3'b000, 1, 200,  9, 1,   0, 2'b10, 2'b10, 0));
    tbl.push_back(mk(0, 3'b000, 1, 200,  1, 1,  32, 2'b10, 2'b10, 0));
    tbl.push_back(mk(0, 3'b000, 1, 200, 10, 1,  64, 2'b10, 2'b10, 0));
    tbl.push_back(mk(0, 3'b000, 1, 200, 40, 1, 192, 2'b10, 2'b10, 0));
    tbl.push_back(mk(0, 3'b000, 1, 200,  9, 1, 192, 2'b10, 2'b10, 0));
    tbl.push_back(mk(0, 3'b000, 1, 200,  1, 1, 200, 2'b10, 2'b10, 0));
    tbl.push_back(mk(0, 3'b000, 1,  50,  1, 1,  50, 2'b10, 2'b10, 0));
    tbl.push_back(mk(0, 3'b000, 1,  50, 20, 1,  50, 2'b10, 2'b10, 0));
    tbl.push_back(mk(0, 3'b010, 1, 200,  4, 1,  50, 2'b10, 2'b10, 0));
    tbl.push_back(mk(0, 3'b010, 1, 200,  1, 4,   0, 2'b00, 2'b00, 1));
    tbl.push_back(mk(0, 3'b010, 1, 200,  7, 4,   0, 2'b00, 2'b00, 1));
    tbl.push_back(mk(0, 3'b010, 1, 200,  1, 2,   0, 2'b10, 2'b01, 0));
    tbl.push_back(mk(0, 3'b010, 1, 200, 10, 2,  32, 2'b10, 2'b01, 0));

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].reps; k++) cyc(tbl[i].rst, tbl[i].sens, tbl[i].en, tbl[i].dmax);
      check($sformatf("tbl%0d", i), {16'd0, state_o, motor_a, motor_b, duty, busy},
            {16'd0, 3'(tbl[i].e_state), tbl[i].e_a, tbl[i].e_b, 8'(tbl[i].e_duty), tbl[i].e_busy});
    end

    // Glitch rejection: 3-cycle pulse ignored, 4-cycle pulse accepted.
    cur_s = 3'b000; cur_en = 1'b1; cur_dm = 8'd200;
    do_reset();
    step(30);
    check("fwd_before_pulse", 32'(state_o), 32'd1);
    cur_s = 3'b001; step(3);
    cur_s = 3'b000;
    for (int k = 0; k < 10; k++) begin
      step(1);
      check("short_pulse_hold", 32'(state_o), 32'd1);
    end
    cur_s = 3'b001; step(4);
    check("pulse4_deb_edge", 32'(state_o), 32'd1);
    cur_s = 3'b000; step(1);
    check("pulse4_coast", {busy, state_o}, {1'b1, 3'd4});
    step(7);
    check("pulse4_coast_end", 32'(state_o), 32'd4);
    step(1);
    check("pulse4_left", {motor_a, motor_b, state_o}, {2'b01, 2'b10, 3'd3});

    // Deferred change in LEFT is taken only once dwell saturates.
    cur_s = 3'b001;
    do_reset();
    step(5);
    check("left_entry", 32'(state_o), 32'd3);
    step(5);
    cur_s = 3'b000;
    step(11);
    check("left_dwell_hold", 32'(state_o), 32'd3);
    step(1);
    check("left_to_coast", 32'(state_o), 32'd4);
    step(7);
    check("left_coast_len", 32'(state_o), 32'd4);
    step(1);
    check("coast_to_fwd", 32'(state_o), 32'd1);

    // Enable drop in COAST, then reset in RIGHT.
    cur_s = 3'b010;
    wait_state(4, 60, "reach_coast");
    step(3);
    cur_en = 1'b0; step(1);
    check("en_drop", {busy, state_o, duty}, {1'b0, 3'd0, 8'd0});
    cur_en = 1'b1; step(1);
    check("reenable_right", 32'(state_o), 32'd2);
    step(12);
    do_reset();
    check("reset_mid_right", {busy, state_o, motor_a, motor_b, duty}, 0);

    // Ceiling drop at duty 128.
    cur_s = 3'b000; cur_dm = 8'd200;
    do_reset();
    begin
      int k;
      k = 0;
      while (duty !== 8'd128 && k < 100) begin step(1); k++; end
    end
    check("duty128", {state_o, duty}, {3'd1, 8'd128});
    cur_dm = 8'd50; step(1);
    check("duty_clamp", 32'(duty), 32'd50);
    step(25);
    check("duty_clamp_hold", 32'(duty), 32'd50);

    // Randomized stimulus against the model.
    cur_s = 3'b000; cur_en = 1'b1; cur_dm = 8'd200;
    do_reset();
    hold = 0; en_off = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        cur_s = 3'($urandom_range(0, 7));
        hold  = $urandom_range(1, 40);
      end else hold--;
      if ($urandom_range(0, 99) == 0) cur_dm = 8'($urandom_range(0, 255));
      if (en_off > 0) begin en_off--; cur_en = (en_off == 0); end
      else if ($urandom_range(0, 149) == 0) begin en_off = $urandom_range(1, 5); cur_en = 1'b0; end
      if ($urandom_range(0, 299) == 0) do_reset();
      else step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/motion_sequencer.md
Name: motion_sequencer

Overview:
Supervisory controller for the line-follower motor datapath. It debounces the three line sensors and selects a motion (standby, forward, right, left). Each motion is held for a minimum dwell time, and a dead-time coast is inserted between motions so the H-bridges never see a direct direction reversal. It also soft-starts a duty-cycle value that feeds the downstream PWM generator.

Parameters:
DEB_CYCLES, 4, consecutive cycles a raw sensor bit must differ from its debounced value before the debounced value updates
DWELL, 16, minimum cycles spent in a motion state before it may be left (except on enable/reset)
DEAD, 8, cycles spent in COAST between two motion states
RAMP_STEP, 32, duty increment per ramp tick
TICK_DIV, 10, clock cycles per ramp tick

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
sensors  input  3  raw {f_sensor, l_sensor, r_sensor}
enable  input  1  run permission; 0 forces STANDBY
duty_max  input  8  ceiling for ramped duty
motor_a  output  2  {fwd, rev} for motor A
motor_b  output  2  {fwd, rev} for motor B
duty  output  8  duty command to the PWM generator
state_o  output  3  STANDBY=0, FORWARD=1, RIGHT=2, LEFT=3, COAST=4
busy  output  1  high while in COAST

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - state=STANDBY, debounced sensors=3'b111, all counters=0.
  - duty=0, motor_a=motor_b=2'b00, busy=0.
- Debounce, per bit:
  - The bit's counter increments while raw differs from debounced; it clears to 0 when they match.
  - When the counter reaches DEB_CYCLES, debounced takes the raw value and the counter clears.
  - A pulse shorter than DEB_CYCLES cycles has no effect.
- Desired motion, decoded from debounced {f,l,r}:
  - 000 or 011 -> FORWARD.
  - 010, 110 or 100 -> RIGHT.
  - 001 or 101 -> LEFT.
  - 111 -> STANDBY.
- Motor decode from the registered state; never drive 2'b11:
  - FORWARD: A=10, B=10.
  - RIGHT: A=10, B=01.
  - LEFT: A=01, B=10.
  - STANDBY and COAST: 00, 00.
- Dwell counter:
  - Clears to 0 on the first cycle of any motion state, then increments and saturates at DWELL.
- Transitions (all effective on the next clock edge):
  - enable=0: go to STANDBY from any state, duty=0, on the next edge. This has the highest priority after reset.
  - STANDBY to a motion: immediate whenever enable=1 and desired != STANDBY; no dwell or coast required.
  - Leaving a motion state: only when dwell==DWELL and desired != current state.
    - If desired is STANDBY, go directly to STANDBY.
    - Otherwise latch desired as the pending target and enter COAST.
  - COAST: lasts exactly DEAD cycles, then goes to the latched target. Sensors are not re-evaluated during COAST.
  - A desired change arriving before dwell expires is deferred, not dropped; it is taken when dwell==DWELL if still desired.
- Duty ramp:
  - duty=0 in STANDBY and COAST, and on the first cycle of every motion state.
  - The tick counter clears on every state entry and counts 0..TICK_DIV-1. A tick fires when it wraps.
  - On each tick in a motion state: duty = min(duty + RAMP_STEP, duty_max). Compute the sum in 9 bits; never wrap.
  - If duty_max falls below duty, duty takes duty_max on the next edge, independent of ticks.
- Latency:
  - Raw sensor change held stable -> debounced update on the DEB_CYCLES-th edge -> state update on the following edge.
  - motor_a, motor_b, state_o and busy follow the state register combinationally.

Test Plan:
- Reset, then sensors=000, enable=1, duty_max=200:
  - State goes to FORWARD 5 cycles after release; motor_a=motor_b=10.
  - duty runs 0,32,64,...,192 and reaches 200 on the 7th tick (70 cycles after entry).
- In FORWARD, r pulses high for 3 cycles -> no state change, debounced unchanged.
  - A 4-cycle pulse is taken as a debounced change.
- In FORWARD (past dwell), sensors=010:
  - COAST for exactly 8 cycles: busy=1, duty=0, motors 00/00.
  - Then RIGHT: A=10, B=01, duty ramps from 0.
- Enter LEFT, apply sensors=000 at dwell count 5 -> LEFT held until dwell=16, then COAST, then FORWARD.
- enable dropped mid-COAST -> STANDBY next cycle, duty=0, busy=0.
  - Assert reset mid-RIGHT -> all outputs at reset values next edge.
- In FORWARD with duty=128, duty_max changed 200->50 -> duty=50 on the next edge and stays at 50 on later ticks.
